// File: rtl/ff_lab_pkg.sv
// Shared flip-flop lab definitions: JK drive codes and the D-from-JK excitation function.
package ff_lab_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // D input that makes a plain D flop behave as a JK flop.
    function automatic logic jk_next(input logic j, input logic k, input logic q);
        return (j & ~q) | (~k & q);
    endfunction

endpackage

// File: rtl/jk_cell.sv
// One counter bit: D flop with async active-low clear, wrapped with JK excitation.
module jk_cell
    import ff_lab_pkg::*;
(
    input  logic clk,
    input  logic clr_bar,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);

    logic q_q;
    logic q_d;

    assign q_d = jk_next(j, k, q_q);

    always_ff @(posedge clk or negedge clr_bar) begin
        if (!clr_bar) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign qbar = ~q_q;

endmodule

// File: rtl/d_to_jk_updown_counter.sv
// Modulo-MODULUS up/down counter built from jk_cell bits; the top only steers J/K
// and produces terminal count and the illegal-load error pulse.
module d_to_jk_updown_counter
    import ff_lab_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             clk,
    input  logic             clr_bar,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             tc,
    output logic             load_err
);

    // One extra bit so MODULUS == 2**WIDTH is representable in the compare.
    localparam int unsigned      CW    = WIDTH + 1;
    localparam logic [CW-1:0]    MOD_W = CW'(MODULUS);
    localparam logic [WIDTH-1:0] TOP_W = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] j_c;
    logic [WIDTH-1:0] k_c;
    logic [WIDTH-1:0] q_c;
    logic [WIDTH-1:0] qbar_c;
    logic             load_ok_c;
    logic             at_top_c;
    logic             at_zero_c;
    logic             ripple_c;
    logic             load_err_q;
    logic             load_err_d;

    assign load_ok_c = ({1'b0, load_val} < MOD_W);
    assign at_top_c  = (q_c == TOP_W);
    assign at_zero_c = (q_c == '0);

    // J/K steering: load beats count beats hold; wraps use explicit set/reset drive.
    always_comb begin
        j_c      = '0;
        k_c      = '0;
        ripple_c = 1'b1;
        if (load) begin
            if (load_ok_c) begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    {j_c[i], k_c[i]} = load_val[i] ? JK_SET : JK_RST;
                end
            end
        end else if (en) begin
            if (up_dn) begin
                if (at_top_c) begin
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        {j_c[i], k_c[i]} = q_c[i] ? JK_RST : JK_HOLD;
                    end
                end else begin
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        {j_c[i], k_c[i]} = ripple_c ? JK_TGL : JK_HOLD;
                        ripple_c         = ripple_c & q_c[i];
                    end
                end
            end else begin
                if (at_zero_c) begin
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        {j_c[i], k_c[i]} = TOP_W[i] ? JK_SET : JK_RST;
                    end
                end else begin
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        {j_c[i], k_c[i]} = ripple_c ? JK_TGL : JK_HOLD;
                        ripple_c         = ripple_c & ~q_c[i];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk     (clk),
            .clr_bar (clr_bar),
            .j       (j_c[g]),
            .k       (k_c[g]),
            .q       (q_c[g]),
            .qbar    (qbar_c[g])
        );
    end

    assign load_err_d = load & ~load_ok_c;

    always_ff @(posedge clk or negedge clr_bar) begin
        if (!clr_bar) begin
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load_err_d;
        end
    end

    assign tc       = en & ~load & ((up_dn & at_top_c) | (~up_dn & at_zero_c));
    assign Q        = q_c;
    assign Qbar     = qbar_c;
    assign load_err = load_err_q;

endmodule
